// File: rtl/wb_rr_snoop_arbiter.sv
// Wishbone B3 N-master to 1-slave round-robin arbiter with write-snoop broadcast.
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no grant; pick next requester after last_idx (round robin)
// ST_BUSY | gnt_idx owns the slave until it drops its m_cyc_i
module wb_rr_snoop_arbiter #(
   parameter int MASTERS = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_ni,
   input  logic [MASTERS*AW-1:0]   m_adr_i,
   input  logic [MASTERS*DW-1:0]   m_dat_i,
   input  logic [MASTERS*DW/8-1:0] m_sel_i,
   input  logic [MASTERS-1:0]      m_we_i,
   input  logic [MASTERS-1:0]      m_cyc_i,
   input  logic [MASTERS-1:0]      m_stb_i,
   input  logic [MASTERS*3-1:0]    m_cti_i,
   input  logic [MASTERS*2-1:0]    m_bte_i,
   output logic [DW-1:0]           m_dat_o,
   output logic [MASTERS-1:0]      m_ack_o,
   output logic [MASTERS-1:0]      m_err_o,
   output logic [MASTERS-1:0]      m_rty_o,
   output logic [AW-1:0]           s_adr_o,
   output logic [DW-1:0]           s_dat_o,
   output logic [DW/8-1:0]         s_sel_o,
   output logic                    s_we_o,
   output logic                    s_cyc_o,
   output logic                    s_stb_o,
   output logic [2:0]              s_cti_o,
   output logic [1:0]              s_bte_o,
   input  logic [DW-1:0]           s_dat_i,
   input  logic                    s_ack_i,
   input  logic                    s_err_i,
   input  logic                    s_rty_i,
   output logic [MASTERS-1:0]      grant_o,
   output logic [AW-1:0]           snoop_adr_o,
   output logic                    snoop_en_o,
   output logic [$clog2(MASTERS)-1:0] snoop_src_o
);

   localparam int IW = $clog2(MASTERS);
   localparam int SW = DW / 8;

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   gnt_idx, gnt_idx_nxt;
   logic [IW-1:0]   last_idx, last_idx_nxt;
   logic [IW-1:0]   rr_pick;
   logic            rr_found;
   logic            busy;
   logic            to_hit;
   logic            snoop_hit;

   logic [AW-1:0]   g_adr;
   logic [DW-1:0]   g_dat;
   logic [SW-1:0]   g_sel;
   logic            g_we, g_cyc, g_stb;
   logic [2:0]      g_cti;
   logic [1:0]      g_bte;
   logic [MASTERS-1:0] grant_vec;

   assign busy = (state == ST_BUSY);

   // Search starts one past the last owner so every requester is reached within MASTERS grants.
   always_comb begin
      int          cand;
      logic [IW-1:0] cand_idx;
      rr_pick  = last_idx;
      rr_found = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int i = 1; i <= MASTERS; i++) begin
         cand = int'(last_idx) + i;
         if (cand >= MASTERS) cand = cand - MASTERS;
         cand_idx = IW'(cand);
         if (!rr_found && m_cyc_i[cand_idx]) begin
            rr_found = 1'b1;
            rr_pick  = cand_idx;
         end
      end
   end

   always_comb begin
      grant_vec = '0;
      if (busy) grant_vec[gnt_idx] = 1'b1;
   end

   always_comb begin
      g_adr = m_adr_i[gnt_idx*AW +: AW];
      g_dat = m_dat_i[gnt_idx*DW +: DW];
      g_sel = m_sel_i[gnt_idx*SW +: SW];
      g_we  = m_we_i[gnt_idx];
      g_cyc = m_cyc_i[gnt_idx];
      g_stb = m_stb_i[gnt_idx];
      g_cti = m_cti_i[gnt_idx*3 +: 3];
      g_bte = m_bte_i[gnt_idx*2 +: 2];
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state    <= ST_IDLE;
         gnt_idx  <= '0;
         last_idx <= IW'(MASTERS - 1);
      end else begin
         state    <= state_nxt;
         gnt_idx  <= gnt_idx_nxt;
         last_idx <= last_idx_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      gnt_idx_nxt  = gnt_idx;
      last_idx_nxt = last_idx;
      case (state)
         ST_IDLE: begin
            if (rr_found) begin
               state_nxt   = ST_BUSY;
               gnt_idx_nxt = rr_pick;
            end
         end
         ST_BUSY: begin
            if (!g_cyc) begin
               state_nxt    = ST_IDLE;
               last_idx_nxt = gnt_idx;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Slave side is zero whenever nobody owns the bus, so reset drops s_cyc_o without a clock.
   always_comb begin
      s_adr_o = busy ? g_adr : '0;
      s_dat_o = busy ? g_dat : '0;
      s_sel_o = busy ? g_sel : '0;
      s_we_o  = busy & g_we;
      s_cyc_o = busy & g_cyc;
      s_stb_o = busy & g_stb & ~to_hit;
      s_cti_o = busy ? g_cti : 3'b000;
      s_bte_o = busy ? g_bte : 2'b00;
   end

   assign grant_o = grant_vec;
   assign m_dat_o = s_dat_i;
   assign m_ack_o = s_ack_i ? grant_vec : '0;
   assign m_rty_o = s_rty_i ? grant_vec : '0;
   assign m_err_o = (s_err_i | to_hit) ? grant_vec : '0;

`ifdef WB_ARB_TIMEOUT_EN
   logic [15:0] wd_cnt;
   logic        wd_resp;

   assign wd_resp = s_ack_i | s_err_i | s_rty_i;
   // Terminal count is TIMEOUT-1 so the error lands in the TIMEOUT-th stalled cycle.
   assign to_hit  = busy & g_stb & ~wd_resp & (wd_cnt == 16'(TIMEOUT - 1));

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         wd_cnt <= '0;
      end else if (!busy || wd_resp || to_hit) begin
         wd_cnt <= '0;
      end else if (g_stb) begin
         wd_cnt <= wd_cnt + 16'd1;
      end
   end
`else
   logic [15:0] unused_timeout;
   assign unused_timeout = 16'(TIMEOUT);
   assign to_hit         = 1'b0;
`endif

   assign snoop_hit = busy & g_we & g_stb & s_ack_i;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         snoop_en_o  <= 1'b0;
         snoop_adr_o <= '0;
         snoop_src_o <= '0;
      end else begin
         snoop_en_o <= snoop_hit;
         if (snoop_hit) begin
            snoop_adr_o <= g_adr;
            snoop_src_o <= gnt_idx;
         end
      end
   end

endmodule

// File: tb/tb_wb_rr_snoop_arbiter.sv
// Scoreboard bench for wb_rr_snoop_arbiter: stimulus pushes expected grants, snoops and errors; a negedge monitor pops and compares.
module tb_wb_rr_snoop_arbiter;
   localparam int M  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [M*AW-1:0]   m_adr_i;
   logic [M*DW-1:0]   m_dat_i;
   logic [M*DW/8-1:0] m_sel_i;
   logic [M-1:0]      m_we_i, m_cyc_i, m_stb_i;
   logic [M*3-1:0]    m_cti_i;
   logic [M*2-1:0]    m_bte_i;
   logic [DW-1:0]     m_dat_o;
   logic [M-1:0]      m_ack_o, m_err_o, m_rty_o;
   logic [AW-1:0]     s_adr_o;
   logic [DW-1:0]     s_dat_o;
   logic [DW/8-1:0]   s_sel_o;
   logic              s_we_o, s_cyc_o, s_stb_o;
   logic [2:0]        s_cti_o;
   logic [1:0]        s_bte_o;
   logic [DW-1:0]     s_dat_i;
   logic              s_ack_i, s_err_i, s_rty_i;
   logic [M-1:0]      grant_o;
   logic [AW-1:0]     snoop_adr_o;
   logic              snoop_en_o;
   logic [1:0]        snoop_src_o;

   wb_rr_snoop_arbiter #(.MASTERS(M), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
      .grant_o(grant_o), .snoop_adr_o(snoop_adr_o), .snoop_en_o(snoop_en_o),
      .snoop_src_o(snoop_src_o)
   );

   typedef struct { logic [AW-1:0] adr; logic [1:0] src; } snp_t;
   typedef struct { logic [M-1:0] v; int c; } err_t;

   logic [M-1:0] gq[$];
   snp_t         sq[$];
   err_t         eq[$];
   snp_t         se;
   err_t         ee;
   int           checks = 0;
   int           errors = 0;
   int           cyc_n = 0;
   int           snoop_seen = 0;
   logic [M-1:0] prev_g = '0;

   always @(posedge clk) cyc_n++;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (grant_o != '0 && grant_o != prev_g) begin
            if (gq.size() == 0) chk("grant_unexpected", grant_o, 0);
            else chk("grant_order", grant_o, gq.pop_front());
         end
         prev_g = grant_o;
         if (snoop_en_o) begin
            snoop_seen++;
            if (sq.size() == 0) chk("snoop_unexpected", snoop_en_o, 0);
            else begin
               se = sq.pop_front();
               chk("snoop_adr", snoop_adr_o, se.adr);
               chk("snoop_src", snoop_src_o, se.src);
            end
         end
         if (m_err_o != '0) begin
            if (eq.size() == 0) chk("err_unexpected", m_err_o, 0);
            else begin
               ee = eq.pop_front();
               chk("err_vec", m_err_o, ee.v);
               chk("err_cycle", cyc_n, ee.c);
            end
         end
         if (grant_o == '0) chk("idle_no_cyc_stb", {s_cyc_o, s_stb_o}, 0);
         chk("ack_route", m_ack_o, s_ack_i ? grant_o : '0);
         chk("rty_route", m_rty_o, s_rty_i ? grant_o : '0);
      end else begin
         prev_g = '0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(int k, logic [AW-1:0] adr, logic we, logic cyc, logic stb, logic [2:0] cti);
      m_adr_i[k*AW +: AW]     = adr;
      m_dat_i[k*DW +: DW]     = adr ^ 32'hA5A5_0000;
      m_sel_i[k*4 +: 4]       = 4'hF;
      m_we_i[k]               = we;
      m_cyc_i[k]              = cyc;
      m_stb_i[k]              = stb;
      m_cti_i[k*3 +: 3]       = cti;
      m_bte_i[k*2 +: 2]       = 2'b00;
   endtask

   task automatic clear_all();
      for (int k = 0; k < M; k++) set_m(k, '0, 1'b0, 1'b0, 1'b0, 3'b000);
      s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic wait_grant(output int k);
      k = -1;
      for (int i = 0; i < 20 && grant_o == '0; i++) step();
      if (grant_o == '0) chk("grant_wait_timeout", grant_o, 1);
      for (int i = 0; i < M; i++) if (grant_o[i]) k = i;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      int k;
      int c0;
      s_dat_i = 32'h0;
      rst_n = 1'b0;
      clear_all();
      #2;
      chk("rst_grant", grant_o, 0);
      chk("rst_s_cyc", s_cyc_o, 0);
      do_reset();
      chk("rst_snoop_en", snoop_en_o, 0);
      chk("rst_snoop_adr", snoop_adr_o, 0);
      chk("rst_snoop_src", snoop_src_o, 0);
      chk("rst_s_adr", s_adr_o, 0);

      // Single read from master 2
      set_m(2, 32'h0000_2000, 1'b0, 1'b1, 1'b1, 3'b000);
      gq.push_back(4'b0100);
      chk("t1_not_yet", grant_o, 0);
      step();
      chk("t1_grant", grant_o, 4'b0100);
      chk("t1_s_adr", s_adr_o, 32'h2000);
      chk("t1_s_cyc", s_cyc_o, 1);
      s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
      #1;
      chk("t1_ack", m_ack_o, 4'b0100);
      chk("t1_dat", m_dat_o, 32'hDEAD_BEEF);
      step();
      s_ack_i = 1'b0;
      set_m(2, '0, 1'b0, 1'b0, 1'b0, 3'b000);
      step();
      chk("t1_release", grant_o, 0);

      // Round robin with all four requesting
      do_reset();
      gq.push_back(4'b0001); gq.push_back(4'b0010); gq.push_back(4'b0100);
      gq.push_back(4'b1000); gq.push_back(4'b0001);
      for (int i = 0; i < M; i++) set_m(i, 32'h1000 * i, 1'b0, 1'b1, 1'b1, 3'b000);
      step();
      for (int n = 0; n < 5; n++) begin
         wait_grant(k);
         s_ack_i = 1'b1;
         step();
         s_ack_i = 1'b0;
         if (k >= 0) set_m(k, '0, 1'b0, 1'b0, 1'b0, 3'b000);
         step();
         chk("t2_gap", grant_o, 0);
         if (n < 4) begin
            if (k >= 0) set_m(k, 32'h1000 * k, 1'b0, 1'b1, 1'b1, 3'b000);
            step();
            chk("t2_regrant_after_gap", grant_o != '0, 1);
         end else begin
            clear_all();
         end
      end
      step();

      // Write burst from master 1 while master 0 waits
      do_reset();
      set_m(1, 32'h100, 1'b1, 1'b1, 1'b1, 3'b010);
      gq.push_back(4'b0010);
      step();
      set_m(0, 32'h40, 1'b0, 1'b1, 1'b1, 3'b000);
      for (int b = 0; b < 4; b++) begin
         set_m(1, 32'h100 + 4 * b, 1'b1, 1'b1, 1'b1, (b == 3) ? 3'b111 : 3'b010);
         s_ack_i = 1'b1;
         sq.push_back('{adr: 32'h100 + 4 * b, src: 2'd1});
         chk("t3_hold", grant_o, 4'b0010);
         step();
      end
      s_ack_i = 1'b0;
      set_m(1, '0, 1'b0, 1'b0, 1'b0, 3'b000);
      chk("t3_hold_last", grant_o, 4'b0010);
      step();
      chk("t3_gap", grant_o, 0);
      gq.push_back(4'b0001);
      step();
      chk("t3_m0_grant", grant_o, 4'b0001);
      s_ack_i = 1'b1;
      step();
      s_ack_i = 1'b0;
      set_m(0, '0, 1'b0, 1'b0, 1'b0, 3'b000);
      step(); step();

      // Master 3: read ack, write err, write rty -> no snoops
      set_m(3, 32'h300, 1'b0, 1'b1, 1'b1, 3'b000);
      gq.push_back(4'b1000);
      step();
      s_ack_i = 1'b1;
      step();
      s_ack_i = 1'b0;
      set_m(3, 32'h304, 1'b1, 1'b1, 1'b1, 3'b000);
      s_err_i = 1'b1;
      eq.push_back('{v: 4'b1000, c: cyc_n});
      step();
      s_err_i = 1'b0;
      s_rty_i = 1'b1;
      step();
      s_rty_i = 1'b0;
      set_m(3, '0, 1'b0, 1'b0, 1'b0, 3'b000);
      step();
      chk("t4_no_snoop_en", snoop_en_o, 0);
      step();
      chk("t4_snoop_total", snoop_seen, 4);

      // Stalled write: watchdog
      do_reset();
      set_m(2, 32'h500, 1'b1, 1'b1, 1'b1, 3'b000);
      gq.push_back(4'b0100);
      step();
      c0 = cyc_n;
`ifdef WB_ARB_TIMEOUT_EN
      eq.push_back('{v: 4'b0100, c: c0 + TO - 1});
`endif
      repeat (TO - 2) step();
      chk("t5_stb_before", s_stb_o, 1);
      chk("t5_err_before", m_err_o, 0);
      step();
`ifdef WB_ARB_TIMEOUT_EN
      chk("t5_stb_forced_low", s_stb_o, 0);
      chk("t5_err_fires", m_err_o, 4'b0100);
`else
      chk("t5_stb_still_high", s_stb_o, 1);
      chk("t5_no_err", m_err_o, 0);
`endif
      step();
      chk("t5_err_one_cycle", m_err_o, 0);
      chk("t5_stb_after", s_stb_o, 1);
      chk("t5_grant_kept", grant_o, 4'b0100);
      set_m(2, '0, 1'b0, 1'b0, 1'b0, 3'b000);
      step(); step();

      // Async reset in the middle of a burst
      do_reset();
      set_m(1, 32'h600, 1'b1, 1'b1, 1'b1, 3'b010);
      gq.push_back(4'b0010);
      step();
      chk("t6_grant", grant_o, 4'b0010);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_grant", grant_o, 0);
      chk("t6_async_cyc", s_cyc_o, 0);
      set_m(0, 32'h700, 1'b0, 1'b1, 1'b1, 3'b000);
      set_m(3, 32'h800, 1'b0, 1'b1, 1'b1, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      gq.push_back(4'b0001);
      step();
      chk("t6_m0_first", grant_o, 4'b0001);
      clear_all();
      step(); step();

      chk("grant_queue_empty", gq.size(), 0);
      chk("snoop_queue_empty", sq.size(), 0);
      chk("err_queue_empty", eq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
